// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
//   uart_rx_state_t           receiver FSM states
//   UART_CLKS_PER_BIT_DEFAULT default oversampling (8 MHz / 125 kbaud)
//   maj3()                    2-of-3 vote used when UART_RX_MAJORITY_EN is defined
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 64;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: FWFT read port of the receive FIFO.
//   rd_valid  FIFO non-empty, rd_data holds the head byte
//   rd_data   head byte
//   rd_en     pop the head byte (ignored while rd_valid=0)
// master = FIFO side, slave = consumer side.
interface uart_rx_fifo_if;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_en;

  modport master (output rd_valid, output rd_data, input rd_en);
  modport slave  (input rd_valid, input rd_data, output rd_en);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with explicit count.
//   clk, rst      clock, async active-high reset
//   push_i/data_i write request; accepted when not full, or full with a same-cycle pop
//   pop_i         pop request; ignored when empty
//   data_o        head entry (0 while empty)
//   full_o/empty_o occupancy flags
//   count_o       occupancy, count_nxt_o = occupancy after this edge
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] count_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // When full, the write slot equals the head slot being popped, so overwrite is safe.
  assign do_push = push_i & (~full_o | do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  assign data_o      = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a FWFT byte FIFO, with rts flow control.
//   clk, rst       8 MHz clock, async active-high reset
//   rx_i           serial input, idle high (asynchronous)
//   rts_o          1 = host must stop sending
//   rd_if          FWFT read port (master side)
//   count_o        FIFO occupancy
//   frame_err_o    sticky, stop bit sampled as 0
//   overrun_o      sticky, byte completed while FIFO full (and not popped)
//   err_clr_i      clears both sticky flags; a same-cycle new error wins
// Optional macro UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote over
// mid-bit-1/mid-bit/mid-bit+1, taken at mid-bit+1 (all pushes 1 clk later).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8,
  parameter int RTS_MARGIN   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  output logic                        rts_o,
  uart_rx_fifo_if.master              rd_if,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  input  logic                        err_clr_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] START_LOAD = TW'(CLKS_PER_BIT / 2);
`else
  localparam logic [TW-1:0] START_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [CW-1:0] RTS_TH = CW'(FIFO_DEPTH - RTS_MARGIN);

  // Synchroniser and edge history; all reset to idle-high.
  logic rx_meta_q, rx_s_q, rx_d1_q;
  // Fills with 1s after reset; falls are only trusted once every history
  // stage holds a real pin sample, so a line held low through reset does not
  // look like a fresh start edge.
  logic [2:0] vld_pipe_q;
  logic       bit_s;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_d2_q <= 1'b1;
    else     rx_d2_q <= rx_d1_q;
  end
  assign bit_s = maj3(rx_s_q, rx_d1_q, rx_d2_q);
`else
  assign bit_s = rx_s_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_d1_q    <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      rx_d1_q    <= rx_s_q;
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
    end
  end

  // Receiver FSM
  uart_rx_state_t state_q;
  logic [TW-1:0]  tmr_q;
  logic [2:0]     idx_q;
  logic [7:0]     shreg_q;
  logic           push_q;
  logic           frame_err_q;
  logic           tmr_done;

  assign tmr_done = (tmr_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr_i) frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vld_pipe_q[2] && rx_d1_q && !rx_s_q) begin
            tmr_q   <= START_LOAD;
            state_q <= START;
          end
        end
        START: begin
          if (tmr_done) begin
            if (bit_s) state_q <= IDLE;   // glitch shorter than half a bit
            else begin
              tmr_q   <= BIT_LOAD;
              idx_q   <= '0;
              state_q <= DATA;
            end
          end else tmr_q <= tmr_q - 1'b1;
        end
        DATA: begin
          if (tmr_done) begin
            shreg_q <= {bit_s, shreg_q[7:1]};  // LSB first
            tmr_q   <= BIT_LOAD;
            if (idx_q == 3'd7) state_q <= STOP;
            else               idx_q   <= idx_q + 1'b1;
          end else tmr_q <= tmr_q - 1'b1;
        end
        STOP: begin
          if (tmr_done) begin
            if (bit_s) begin
              push_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else tmr_q <= tmr_q - 1'b1;
        end
        BREAK: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, fifo_count_nxt;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .data_i      (shreg_q),
    .pop_i       (rd_if.rd_en),
    .data_o      (rd_if.rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .count_nxt_o (fifo_count_nxt)
  );

  assign rd_if.rd_valid = ~fifo_empty;
  assign count_o        = fifo_count;

  // Overrun and rts. Full implies non-empty, so rd_en alone means a real pop.
  logic overrun_q, rts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      rts_q     <= 1'b1;
    end else begin
      if (push_q && fifo_full && !rd_if.rd_en) overrun_q <= 1'b1;
      else if (err_clr_i)                      overrun_q <= 1'b0;
      rts_q <= (fifo_count_nxt >= RTS_TH);
    end
  end

  assign rts_o       = rts_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB = 64;
  localparam int D   = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int PUSH_K = 37;  // posedges from stop-bit start to the push edge
`else
  localparam int PUSH_K = 36;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       err_clr = 1'b0;
  logic       rts, fe, ovr;
  logic [3:0] count;
  logic       mon_pop = 1'b0, tb_pop = 1'b0, auto_pop = 1'b0;

  int errs = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if rd_if();
  assign rd_if.rd_en = mon_pop | tb_pop;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(D), .RTS_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .rx_i(rx), .rts_o(rts), .rd_if(rd_if),
    .count_o(count), .frame_err_o(fe), .overrun_o(ovr), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every popped head byte against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rd_if.rd_valid && (auto_pop || tb_pop)) begin
        if (exp_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_pop: got %0h expected none", rd_if.rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {24'd0, rd_if.rd_data}, {24'd0, e});
        end
        if (auto_pop) begin
          mon_pop = 1'b1;
          @(posedge clk);
          #1 mon_pop = 1'b0;
        end
      end
    end
  end

  // Serial frame; glitch_bit>=0 inverts rx for one clk at that data bit's mid-point.
  task automatic send(input logic [7:0] b, input logic stop, input bit pop_at_push,
                      input int glitch_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (glitch_bit == i) begin
        repeat (32) @(negedge clk);
        rx = ~b[i];
        @(negedge clk);
        rx = b[i];
        repeat (CPB - 33) @(negedge clk);
      end else repeat (CPB) @(negedge clk);
    end
    rx = stop;
    if (pop_at_push) begin
      repeat (PUSH_K - 1) @(posedge clk);
      #1 tb_pop = 1'b1;
      @(posedge clk);
      #1 tb_pop = 1'b0;
      repeat (CPB - PUSH_K) @(negedge clk);
    end else repeat (CPB) @(negedge clk);
    if (stop) rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_if.rd_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, n < 2000}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rts", {31'd0, rts}, 32'd1);
    chk("rst_valid", {31'd0, rd_if.rd_valid}, 32'd0);
    chk("rst_data", {24'd0, rd_if.rd_data}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_ferr", {31'd0, fe}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rts_after_rst", {31'd0, rts}, 32'd0);
    repeat (4) @(negedge clk);

    // 1: four bytes, popped as they arrive
    auto_pop = 1'b1;
    exp_q.push_back(8'hDE); send(8'hDE, 1'b1, 0, -1);
    exp_q.push_back(8'hAD); send(8'hAD, 1'b1, 0, -1);
    exp_q.push_back(8'hBE); send(8'hBE, 1'b1, 0, -1);
    exp_q.push_back(8'hEF); send(8'hEF, 1'b1, 0, -1);
    drain("c1_drain");
    chk("c1_ferr", {31'd0, fe}, 32'd0);
    chk("c1_ovr", {31'd0, ovr}, 32'd0);
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'hC3); send(8'hC3, 1'b1, 0, 2);
    exp_q.push_back(8'h3C); send(8'h3C, 1'b1, 0, 5);
    drain("maj_drain");
`endif

    // 2: short low pulse is not a start bit
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("c2_count", {28'd0, count}, 32'd0);
    chk("c2_state", {29'd0, dut.state_q}, {29'd0, IDLE});

    // 3: framing error, held-low break, then a good byte
    send(8'h55, 1'b0, 0, -1);
    chk("c3_ferr", {31'd0, fe}, 32'd1);
    chk("c3_count", {28'd0, count}, 32'd0);
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back(8'h12); send(8'h12, 1'b1, 0, -1);
    drain("c3_drain");
    chk("c3_count_after", {28'd0, count}, 32'd0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("c3_ferr_clr", {31'd0, fe}, 32'd0);

    // 4: fill without popping, rts threshold, then overrun
    auto_pop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(8'(k));
      send(8'(k), 1'b1, 0, -1);
      chk("c4_count", {28'd0, count}, 32'(k));
      chk("c4_rts", {31'd0, rts}, {31'd0, k >= 6});
    end
    send(8'h09, 1'b1, 0, -1);
    chk("c4_ovr", {31'd0, ovr}, 32'd1);
    chk("c4_count_full", {28'd0, count}, 32'd8);
    chk("c4_head", {24'd0, rd_if.rd_data}, 32'h01);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("c4_ovr_clr", {31'd0, ovr}, 32'd0);

    // 5: full FIFO, pop in the push cycle
    exp_q.push_back(8'h0A);
    send(8'h0A, 1'b1, 1, -1);
    chk("c5_count", {28'd0, count}, 32'd8);
    chk("c5_ovr", {31'd0, ovr}, 32'd0);
    auto_pop = 1'b1;
    drain("c5_drain");

    // 6: reset during data bit 4 of 0xA5
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hA5 >> i);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;  // bit 4 of 0xA5
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("c6_rts", {31'd0, rts}, 32'd1);
    chk("c6_valid", {31'd0, rd_if.rd_valid}, 32'd0);
    chk("c6_count", {28'd0, count}, 32'd0);
    chk("c6_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("c6_no_start", {29'd0, dut.state_q}, {29'd0, IDLE});
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back(8'h3C); send(8'h3C, 1'b1, 0, -1);
    drain("c6_drain");
    chk("c6_ferr", {31'd0, fe}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
